// File: rtl/smd_pkg.sv
// Shared constants for the six-button pad front end: button bit indices,
// the button count, the all-released level, and a counter-width helper.
package smd_pkg;

    localparam int NUM_BTN = 12;

    // Bit positions inside btn_raw / btn_db / btn_chg
    localparam int BTN_UP = 0;
    localparam int BTN_DW = 1;
    localparam int BTN_LF = 2;
    localparam int BTN_RG = 3;
    localparam int BTN_A  = 4;
    localparam int BTN_B  = 5;
    localparam int BTN_C  = 6;
    localparam int BTN_ST = 7;
    localparam int BTN_X  = 8;
    localparam int BTN_Y  = 9;
    localparam int BTN_Z  = 10;
    localparam int BTN_MD = 11;

    // Active-low contacts: all ones means nothing pressed
    localparam logic [NUM_BTN-1:0] BTN_RELEASED = 12'hFFF;

    // Width for a counter holding 0..n-1, never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/smd_debounce_bit.sv
// One button lane: two-flop synchroniser, tick-qualified disagreement
// counter, debounced output flop and a one-cycle change pulse.
module smd_debounce_bit
    import smd_pkg::*;
#(
    parameter int DB_TICKS = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic raw,
    output logic db,
    output logic chg
);

    localparam int              CNT_W = cnt_width(DB_TICKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_TICKS - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             db_q;
    logic             db_d;
    logic             chg_q;
    logic             chg_d;

    // Bring the asynchronous contact into the clk domain (idle level is 1)
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive disagreeing ticks; any agreeing tick restarts the count
    always_comb begin
        cnt_d = cnt_q;
        db_d  = db_q;
        chg_d = 1'b0;
        if (tick) begin
            if (sync2_q == db_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                db_d  = sync2_q;
                cnt_d = '0;
                chg_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Counter, debounced level and change pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            db_q  <= 1'b1;
            chg_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            db_q  <= db_d;
            chg_q <= chg_d;
        end
    end

    assign db  = db_q;
    assign chg = chg_q;

endmodule

// File: rtl/smd_button_debouncer.sv
// Twelve-button debouncer: a shared prescaler produces the sample tick and
// each button runs through its own independent debounce lane.
module smd_button_debouncer
    import smd_pkg::*;
#(
    parameter int TICK_DIV = 10000,
    parameter int DB_TICKS = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_db,
    output logic [NUM_BTN-1:0] btn_chg,
    output logic               tick
);

    localparam int                PRESC_W    = $clog2(TICK_DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_d;
    logic               tick_q;
    logic               tick_d;

    // Prescaler wraps after TICK_DIV-1; tick fires the cycle after the wrap value
    always_comb begin
        presc_d = presc_q + 1'b1;
        tick_d  = 1'b0;
        if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            tick_d  = 1'b1;
        end
    end

    // Prescaler and registered tick
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
        end
    end

    assign tick = tick_q;

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_lane
            smd_debounce_bit #(
                .DB_TICKS (DB_TICKS)
            ) u_lane (
                .clk  (clk),
                .rst  (rst),
                .tick (tick_q),
                .raw  (btn_raw[gi]),
                .db   (btn_db[gi]),
                .chg  (btn_chg[gi])
            );
        end
    endgenerate

endmodule
